// File: rtl/menu_command_executor.sv
// -----------------------------------------------------------------------------
// menu_command_executor
//
// Carries out the file commands raised by the editor menu controller:
//   New   (nuevo)   - blank every cell of the character text buffer
//   Save  (guardar) - stream the whole buffer out over a valid/ready port
//   Close (cerrar)  - lock keyboard editing until the next New
// Each finished command is reported with a one-cycle pulse on cmd_done.
//
// Ports
//   clk, reset                    system clock, asynchronous active-high reset
//   cmd_nuevo/guardar/cerrar      sticky command levels; rising edges queue work
//   buf_addr/buf_wdata/buf_we     text buffer RAM write/read address side
//   buf_rdata                     RAM read data, valid one cycle after buf_addr
//   save_data/valid/last, ready   save stream; last marks the final cell
//   editor_en                     1 = keyboard editing allowed
//   busy                          a command is being executed
//   cmd_done                      {cerrar, guardar, nuevo} completion pulse
// -----------------------------------------------------------------------------
module menu_command_executor #(
  parameter int                ADDR_W     = 11,
  parameter int                BUF_DEPTH  = 1200,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] BLANK_CHAR = DATA_W'('h20)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_nuevo,
  input  logic              cmd_guardar,
  input  logic              cmd_cerrar,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              buf_we,
  input  logic [DATA_W-1:0] buf_rdata,
  output logic [DATA_W-1:0] save_data,
  output logic              save_valid,
  output logic              save_last,
  input  logic              save_ready,
  output logic              editor_en,
  output logic              busy,
  output logic [2:0]        cmd_done
);

  // Bit positions inside the 3-bit command vectors (matches cmd_done order).
  localparam int CMD_NUEVO   = 0;
  localparam int CMD_GUARDAR = 1;
  localparam int CMD_CERRAR  = 2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SAVE_RD,
    S_SAVE_WAIT,
    S_SAVE_SEND,
    S_CLOSE,
    S_CLOSED,
    S_FINISH
  } state_t;

  // Registered state
  state_t              state_q;
  logic [2:0]          cmd_prev_q;
  logic [2:0]          pending_q;
  logic [ADDR_W-1:0]   buf_addr_q;
  logic                buf_we_q;
  logic [DATA_W-1:0]   save_data_q;
  logic                save_valid_q;
  logic                save_last_q;
  logic                editor_en_q;
  logic [2:0]          cmd_done_q;

  // Next-state values
  state_t              state_d;
  logic [2:0]          pending_d;
  logic [ADDR_W-1:0]   buf_addr_d;
  logic                buf_we_d;
  logic [DATA_W-1:0]   save_data_d;
  logic                save_valid_d;
  logic                save_last_d;
  logic                editor_en_d;
  logic [2:0]          cmd_done_d;

  logic [2:0]          cmd_level;
  logic [2:0]          cmd_rise;
  logic [2:0]          accept;

  assign cmd_level = {cmd_cerrar, cmd_guardar, cmd_nuevo};
  assign cmd_rise  = cmd_level & ~cmd_prev_q;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    accept       = 3'b000;
    buf_addr_d   = buf_addr_q;
    buf_we_d     = 1'b0;
    save_data_d  = save_data_q;
    save_valid_d = save_valid_q;
    save_last_d  = save_last_q;
    editor_en_d  = editor_en_q;
    cmd_done_d   = 3'b000;

    unique case (state_q)
      S_IDLE: begin
        // Fixed priority: cerrar > guardar > nuevo, one command per visit.
        if (pending_q[CMD_CERRAR]) begin
          accept[CMD_CERRAR] = 1'b1;
          state_d            = S_CLOSE;
          editor_en_d        = 1'b0;
          cmd_done_d         = 3'b100;   // pulse is visible while in CLOSE
        end else if (pending_q[CMD_GUARDAR]) begin
          accept[CMD_GUARDAR] = 1'b1;
          state_d             = S_SAVE_RD;
          buf_addr_d          = '0;
        end else if (pending_q[CMD_NUEVO]) begin
          accept[CMD_NUEVO] = 1'b1;
          state_d           = S_CLEAR;
          buf_addr_d        = '0;
          buf_we_d          = 1'b1;
        end
      end

      S_CLEAR: begin
        // buf_we is high for every cycle spent here, one cell per cycle.
        if (buf_addr_q == LAST_ADDR) begin
          state_d     = S_FINISH;
          editor_en_d = 1'b1;
          cmd_done_d  = 3'b001;
        end else begin
          buf_addr_d = buf_addr_q + ADDR_W'(1);
          buf_we_d   = 1'b1;
        end
      end

      S_SAVE_RD: begin
        // Address is already on the RAM; read data appears next cycle.
        state_d = S_SAVE_WAIT;
      end

      S_SAVE_WAIT: begin
        save_data_d  = buf_rdata;
        save_valid_d = 1'b1;
        save_last_d  = (buf_addr_q == LAST_ADDR);
        state_d      = S_SAVE_SEND;
      end

      S_SAVE_SEND: begin
        // Beat is held untouched until the sink accepts it.
        if (save_ready) begin
          save_valid_d = 1'b0;
          save_last_d  = 1'b0;
          if (save_last_q) begin
            state_d    = S_FINISH;
            cmd_done_d = 3'b010;
          end else begin
            buf_addr_d = buf_addr_q + ADDR_W'(1);
            state_d    = S_SAVE_RD;
          end
        end
      end

      S_CLOSE: begin
        state_d = S_CLOSED;
      end

      S_CLOSED: begin
        // Only New reopens the editor; Save and Close are discarded silently.
        accept[CMD_CERRAR]  = pending_q[CMD_CERRAR];
        accept[CMD_GUARDAR] = pending_q[CMD_GUARDAR];
        if (pending_q[CMD_NUEVO]) begin
          accept[CMD_NUEVO] = 1'b1;
          state_d           = S_CLEAR;
          buf_addr_d        = '0;
          buf_we_d          = 1'b1;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A fresh edge always wins over the clear of an accepted command.
    pending_d = (pending_q & ~accept) | cmd_rise;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q      <= S_IDLE;
      // Edge detectors track the live levels during reset, so a command flag
      // that is already high when reset drops never looks like a new edge.
      cmd_prev_q   <= cmd_level;
      pending_q    <= 3'b000;
      buf_addr_q   <= '0;
      buf_we_q     <= 1'b0;
      save_data_q  <= '0;
      save_valid_q <= 1'b0;
      save_last_q  <= 1'b0;
      editor_en_q  <= 1'b1;
      cmd_done_q   <= 3'b000;
    end else begin
      state_q      <= state_d;
      cmd_prev_q   <= cmd_level;
      pending_q    <= pending_d;
      buf_addr_q   <= buf_addr_d;
      buf_we_q     <= buf_we_d;
      save_data_q  <= save_data_d;
      save_valid_q <= save_valid_d;
      save_last_q  <= save_last_d;
      editor_en_q  <= editor_en_d;
      cmd_done_q   <= cmd_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b1;
    if (state_q == S_IDLE || state_q == S_CLOSED) begin
      busy = 1'b0;
    end
  end

  assign buf_addr   = buf_addr_q;
  assign buf_wdata  = BLANK_CHAR;   // the only value ever written
  assign buf_we     = buf_we_q;
  assign save_data  = save_data_q;
  assign save_valid = save_valid_q;
  assign save_last  = save_last_q;
  assign editor_en  = editor_en_q;
  assign cmd_done   = cmd_done_q;

endmodule

// File: tb/tb_menu_command_executor.sv
// -----------------------------------------------------------------------------
// tb_menu_command_executor
//
// Directed sequence plus randomized rounds around menu_command_executor.
// A simple synchronous RAM stands in for the text buffer. The expected buffer
// contents, command completion order and editor lock state come from a small
// model of the command rules kept here.
// -----------------------------------------------------------------------------
module tb_menu_command_executor;

  localparam int          ADDR_W     = 11;
  localparam int          DEPTH      = 1200;
  localparam int          DATA_W     = 8;
  localparam logic [7:0]  BLANK      = 8'h20;
  localparam int          STALL_BEAT = 5;
  localparam int          STALL_LEN  = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_nuevo, cmd_guardar, cmd_cerrar;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;
  logic [DATA_W-1:0] save_data;
  logic              save_valid, save_last, save_ready;
  logic              editor_en, busy;
  logic [2:0]        cmd_done;

  int tests_run    = 0;
  int tests_failed = 0;

  menu_command_executor #(
    .ADDR_W    (ADDR_W),
    .BUF_DEPTH (DEPTH),
    .DATA_W    (DATA_W),
    .BLANK_CHAR(BLANK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_nuevo  (cmd_nuevo),
    .cmd_guardar(cmd_guardar),
    .cmd_cerrar (cmd_cerrar),
    .buf_addr   (buf_addr),
    .buf_wdata  (buf_wdata),
    .buf_we     (buf_we),
    .buf_rdata  (buf_rdata),
    .save_data  (save_data),
    .save_valid (save_valid),
    .save_last  (save_last),
    .save_ready (save_ready),
    .editor_en  (editor_en),
    .busy       (busy),
    .cmd_done   (cmd_done)
  );

  always #5 clk = ~clk;

  // Text buffer RAM: synchronous read, read-before-write, bulk load port.
  logic [7:0] ram   [DEPTH];
  logic [7:0] image [DEPTH];
  logic       load_req;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= image[i];
    end else if (int'(buf_addr) < DEPTH) begin
      buf_rdata <= ram[buf_addr];
      if (buf_we) ram[buf_addr] <= buf_wdata;
    end
  end

  // Reference model state
  logic [7:0] txt [DEPTH];   // what the buffer should hold
  bit         closed;        // editor locked by Close
  logic [2:0] exp_q [$];     // expected completion order

  // Observations from watch()
  logic [2:0] done_q [$];
  logic       en_q   [$];
  logic [7:0] beat_d [$];
  logic       beat_l [$];
  int we_count, we_bad, stab_bad, valid_seen;
  int ready_mode, stall_left, cyc;
  bit timed_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: cell[i] = i mod 256, otherwise random contents
  task automatic load_image(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      image[i] = (mode == 0) ? 8'(i) : 8'($urandom_range(0, 255));
      txt[i]   = image[i];
    end
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic pulse_cmd(input bit c, input bit g, input bit n);
    cmd_cerrar  = c;
    cmd_guardar = g;
    cmd_nuevo   = n;
    step();
    cmd_cerrar  = 1'b0;
    cmd_guardar = 1'b0;
    cmd_nuevo   = 1'b0;
  endtask

  task automatic reset_records();
    done_q.delete();
    en_q.delete();
    beat_d.delete();
    beat_l.delete();
    we_count   = 0;
    we_bad     = 0;
    stab_bad   = 0;
    valid_seen = 0;
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0: save_ready = 1'b1;
      1: begin
        if (save_valid === 1'b1 && beat_d.size() == STALL_BEAT && stall_left > 0) begin
          save_ready = 1'b0;
          stall_left--;
        end else begin
          save_ready = cyc[0];
        end
      end
      default: save_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Run cycle by cycle, recording writes, beats and done pulses. Stops once
  // n_done pulses were seen and the block is idle, or stop_beats beats have
  // been accepted; with both zero it simply runs max_cycles.
  task automatic watch(input int n_done, input int stop_beats, input int max_cycles);
    bit         hold    = 1'b0;
    bit         prev_we = 1'b0;
    logic [7:0] hold_d  = '0;
    logic       hold_l  = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      step();
      if (hold) begin
        if (save_valid !== 1'b1 || save_data !== hold_d || save_last !== hold_l) stab_bad++;
      end
      if (buf_we === 1'b1) begin
        if (int'(buf_addr) != we_count || buf_wdata !== BLANK) we_bad++;
        if (!prev_we && we_count != 0) we_bad++;
        we_count++;
      end
      prev_we = (buf_we === 1'b1);
      if (cmd_done !== 3'b000) begin
        done_q.push_back(cmd_done);
        en_q.push_back(editor_en);
      end
      if (save_valid === 1'b1) valid_seen++;
      drive_ready();
      hold   = (save_valid === 1'b1) && !save_ready;
      hold_d = save_data;
      hold_l = save_last;
      if (save_valid === 1'b1 && save_ready) begin
        beat_d.push_back(save_data);
        beat_l.push_back(save_last);
      end
      if (n_done > 0 && done_q.size() >= n_done && busy === 1'b0 && cmd_done === 3'b000) begin
        timed_out = 1'b0;
        return;
      end
      if (stop_beats > 0 && beat_d.size() >= stop_beats) begin
        timed_out = 1'b0;
        return;
      end
    end
    timed_out = (n_done > 0 || stop_beats > 0);
  endtask

  function automatic logic [31:0] done_at(input int i);
    return (i < done_q.size()) ? {29'd0, done_q[i]} : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] en_at(input int i);
    return (i < en_q.size()) ? {31'd0, en_q[i]} : 32'hxxxx_xxxx;
  endfunction

  function automatic int ram_vs_model();
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== txt[i]) bad++;
    return bad;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) txt[i] = BLANK;
  endtask

  // Stream must be exactly the model text, last flag only on the final cell.
  task automatic check_stream(input string tag);
    check({tag, "_len"}, beat_d.size(), DEPTH);
    for (int i = 0; i < beat_d.size() && i < DEPTH; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), {24'd0, beat_d[i]}, {24'd0, txt[i]});
      check($sformatf("%s_last[%0d]", tag, i), {31'd0, beat_l[i]}, (i == DEPTH - 1) ? 1 : 0);
    end
  endtask

  initial begin
    reset       = 1'b1;
    cmd_nuevo   = 1'b0;
    cmd_guardar = 1'b0;
    cmd_cerrar  = 1'b0;
    save_ready  = 1'b0;
    load_req    = 1'b0;
    ready_mode  = 0;
    stall_left  = 0;
    cyc         = 0;
    closed      = 1'b0;
    timed_out   = 1'b0;
    reset_records();

    // Reset values
    repeat (3) step();
    check("rst_buf_addr",   buf_addr,   0);
    check("rst_buf_wdata",  buf_wdata,  BLANK);
    check("rst_buf_we",     buf_we,     0);
    check("rst_save_data",  save_data,  0);
    check("rst_save_valid", save_valid, 0);
    check("rst_save_last",  save_last,  0);
    check("rst_editor_en",  editor_en,  1);
    check("rst_busy",       busy,       0);
    check("rst_cmd_done",   cmd_done,   0);
    reset = 1'b0;
    step();

    // 1. New blanks every cell in one contiguous burst
    load_image(1);
    reset_records();
    ready_mode = 0;
    pulse_cmd(0, 0, 1);
    watch(1, 0, 3000);
    model_clear();
    check("t1_timeout",  timed_out, 0);
    check("t1_we_count", we_count,  DEPTH);
    check("t1_we_bad",   we_bad,    0);
    check("t1_done_n",   done_q.size(), 1);
    check("t1_done",     done_at(0), 3'b001);
    check("t1_busy",     busy, 0);
    check("t1_ram",      ram_vs_model(), 0);

    // 2. Save with sink always ready, cell[i] = i mod 256
    load_image(0);
    reset_records();
    ready_mode = 0;
    pulse_cmd(0, 1, 0);
    watch(1, 0, 5000);
    check("t2_timeout", timed_out, 0);
    check_stream("t2");
    check("t2_done_n",  done_q.size(), 1);
    check("t2_done",    done_at(0), 3'b010);
    check("t2_we",      we_count, 0);
    check("t2_busy",    busy, 0);

    // 3. Save with toggling ready and a long stall on beat 5
    load_image(1);
    reset_records();
    ready_mode = 1;
    stall_left = STALL_LEN;
    pulse_cmd(0, 1, 0);
    watch(1, 0, 20000);
    check("t3_timeout", timed_out, 0);
    check_stream("t3");
    check("t3_stable",  stab_bad, 0);
    check("t3_stalled", stall_left, 0);
    check("t3_done",    done_at(0), 3'b010);

    // 4. Close and New together: Close first, then the clear reopens
    reset_records();
    ready_mode = 0;
    pulse_cmd(1, 0, 1);
    watch(2, 0, 3000);
    model_clear();
    check("t4_timeout",  timed_out, 0);
    check("t4_done_n",   done_q.size(), 2);
    check("t4_done0",    done_at(0), 3'b100);
    check("t4_en0",      en_at(0), 0);
    check("t4_done1",    done_at(1), 3'b001);
    check("t4_en1",      en_at(1), 1);
    check("t4_we_count", we_count, DEPTH);
    check("t4_editor",   editor_en, 1);
    check("t4_ram",      ram_vs_model(), 0);

    // 5. Save and Close are dropped while closed; New reopens
    reset_records();
    pulse_cmd(1, 0, 0);
    watch(1, 0, 50);
    check("t5_close_done", done_at(0), 3'b100);
    check("t5_close_en",   editor_en, 0);
    reset_records();
    pulse_cmd(0, 1, 0);
    watch(0, 0, 40);
    check("t5_save_valid", valid_seen, 0);
    check("t5_save_done",  done_q.size(), 0);
    check("t5_save_en",    editor_en, 0);
    check("t5_save_busy",  busy, 0);
    reset_records();
    pulse_cmd(1, 0, 0);
    watch(0, 0, 40);
    check("t5_reclose_done", done_q.size(), 0);
    check("t5_reclose_en",   editor_en, 0);
    reset_records();
    pulse_cmd(0, 0, 1);
    watch(1, 0, 3000);
    model_clear();
    check("t5_open_done", done_at(0), 3'b001);
    check("t5_open_en",   editor_en, 1);
    check("t5_open_we",   we_count, DEPTH);

    // 6. Reset in the middle of a save, command levels held through reset
    load_image(1);
    reset_records();
    ready_mode = 0;
    pulse_cmd(0, 1, 0);
    watch(0, 300, 5000);
    check("t6_reach300", timed_out, 0);
    reset = 1'b1;
    #1;
    check("t6_async_valid", save_valid, 0);
    check("t6_async_busy",  busy, 0);
    check("t6_async_last",  save_last, 0);
    cmd_nuevo   = 1'b1;
    cmd_guardar = 1'b1;
    cmd_cerrar  = 1'b1;
    step();
    check("t6_next_valid", save_valid, 0);
    check("t6_next_busy",  busy, 0);
    check("t6_next_addr",  buf_addr, 0);
    step();
    reset = 1'b0;
    reset_records();
    watch(0, 0, 30);
    check("t6_held_done",  done_q.size(), 0);
    check("t6_held_valid", valid_seen, 0);
    check("t6_held_we",    we_count, 0);
    check("t6_held_busy",  busy, 0);
    cmd_nuevo   = 1'b0;
    cmd_guardar = 1'b0;
    cmd_cerrar  = 1'b0;
    watch(0, 0, 5);
    check("t6_fall_done", done_q.size(), 0);
    check("t6_ram",       ram_vs_model(), 0);
    check("t6_editor",    editor_en, 1);
    closed = 1'b0;

    // Randomized rounds: random command mix, random contents, random ready
    for (int r = 0; r < 3; r++) begin
      logic [2:0] m;
      bit         exp_save, exp_clear;
      m         = 3'($urandom_range(1, 7));
      exp_save  = 1'b0;
      exp_clear = 1'b0;
      exp_q.delete();
      load_image(1);
      if (!closed && m[2]) begin
        exp_q.push_back(3'b100);
        closed = 1'b1;
      end
      if (closed) begin
        if (m[0]) begin
          exp_q.push_back(3'b001);
          exp_clear = 1'b1;
          closed    = 1'b0;
        end
      end else begin
        if (m[1]) begin
          exp_q.push_back(3'b010);
          exp_save = 1'b1;
        end
        if (m[0]) begin
          exp_q.push_back(3'b001);
          exp_clear = 1'b1;
        end
      end
      reset_records();
      ready_mode = 2;
      pulse_cmd(m[2], m[1], m[0]);
      if (exp_q.size() > 0) watch(exp_q.size(), 0, 20000);
      else                  watch(0, 0, 40);
      check($sformatf("r%0d_timeout", r), timed_out, 0);
      if (exp_save) check_stream($sformatf("r%0d_save", r));
      else          check($sformatf("r%0d_no_beats", r), beat_d.size(), 0);
      if (exp_clear) model_clear();
      check($sformatf("r%0d_done_n", r), done_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
        check($sformatf("r%0d_done%0d", r, i), done_at(i), {29'd0, exp_q[i]});
      check($sformatf("r%0d_we_count", r), we_count, exp_clear ? DEPTH : 0);
      check($sformatf("r%0d_we_bad", r),   we_bad, 0);
      check($sformatf("r%0d_editor", r),   editor_en, closed ? 0 : 1);
      check($sformatf("r%0d_busy", r),     busy, 0);
      check($sformatf("r%0d_ram", r),      ram_vs_model(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/menu_command_executor.md
Name: menu_command_executor

Overview:
Executes the file commands raised by the editor menu controller: New (nuevo), Save (guardar) and Close (cerrar). It sits between the menu controller's sticky command flags and the character text buffer RAM. It clears the buffer, streams the buffer contents out over a valid/ready save port, and gates editing. Each completed command is reported with a one-cycle done pulse.

Parameters:
ADDR_W, 11, text buffer address width
BUF_DEPTH, 1200, number of character cells (must be ≤ 2**ADDR_W)
DATA_W, 8, character code width
BLANK_CHAR, 8'h20, code written to every cell on New

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_nuevo  in  1  New command level from menu controller (sticky)
cmd_guardar  in  1  Save command level (sticky)
cmd_cerrar  in  1  Close command level (sticky)
buf_addr  out  ADDR_W  text buffer address
buf_wdata  out  DATA_W  text buffer write data
buf_we  out  1  text buffer write enable
buf_rdata  in  DATA_W  text buffer read data, valid 1 cycle after buf_addr
save_data  out  DATA_W  save stream character
save_valid  out  1  save stream valid
save_last  out  1  marks final character (address BUF_DEPTH-1)
save_ready  in  1  save stream sink ready
editor_en  out  1  1 = keyboard editing allowed
busy  out  1  command in progress
cmd_done  out  3  one-cycle pulse {cerrar,guardar,nuevo} on completion

Behaviour:
- Reset values: buf_addr=0, buf_wdata=BLANK_CHAR, buf_we=0, save_data=0, save_valid=0, save_last=0, editor_en=1, busy=0, cmd_done=0, pending=000, state=IDLE. The edge-detect registers are loaded with the current input levels, so flags already high at reset do not fire.
- Edge capture: a rising edge on any cmd_* sets its pending bit, in any state. A pending bit is cleared when its command is accepted. Cerrar is also cleared when discarded in CLOSED (see below).
- Priority when several bits are pending: cerrar > guardar > nuevo. One command is accepted per IDLE visit.
- States:
  - IDLE: busy=0.
    - pending cerrar -> CLOSE.
    - Else pending guardar -> SAVE_RD, with buf_addr=0.
    - Else pending nuevo -> CLEAR, with buf_addr=0.
  - CLEAR: buf_we=1, buf_wdata=BLANK_CHAR, buf_addr increments each cycle.
    - Write at BUF_DEPTH-1 -> FINISH, then pulse cmd_done[0] and set editor_en=1.
    - Takes exactly BUF_DEPTH write cycles.
  - SAVE_RD: drive buf_addr, buf_we=0 -> SAVE_WAIT.
  - SAVE_WAIT: latch buf_rdata into save_data, assert save_valid; save_last=(buf_addr==BUF_DEPTH-1) -> SAVE_SEND.
  - SAVE_SEND: hold save_data, save_valid and save_last stable until save_ready=1. On the handshake cycle:
    - Deassert valid.
    - If last -> FINISH, then pulse cmd_done[1].
    - Else buf_addr+1 -> SAVE_RD.
    - Minimum 3 cycles per character.
  - CLOSE: editor_en=0, pulse cmd_done[2] -> CLOSED.
  - CLOSED: busy=0, editor_en=0.
    - Pending guardar: cleared and ignored, no done pulse.
    - Pending cerrar: cleared and ignored, no done pulse.
    - Pending nuevo -> CLEAR. editor_en returns to 1 at CLEAR completion.
  - FINISH: single cycle; issues the done pulse, buf_we=0 -> IDLE.
- busy=1 in CLEAR, SAVE_RD, SAVE_WAIT, SAVE_SEND, CLOSE, FINISH.
- Commands arriving while busy stay pending and are serviced on return to IDLE.
- buf_addr never exceeds BUF_DEPTH-1. It stays at its last value in IDLE.
- Reset asserted mid-CLEAR or mid-SAVE aborts immediately to reset values. A partial save stream is abandoned and save_last is never sent.

Test Plan:
1. Reset, then rising edge on cmd_nuevo -> buf_we high for exactly 1200 consecutive cycles, addresses 0..1199, all writing 8'h20; then one cmd_done=001 pulse; busy returns to 0.
2. Preload RAM model with cell[i]=i[7:0], save_ready held 1, cmd_guardar edge -> 1200 beats with data 0,1,…,175 (i mod 256); save_last only on beat 1199; cmd_done=010 pulse.
3. Save with save_ready toggling every other cycle and a 20-cycle stall at beat 5 -> save_data, save_valid and save_last stable throughout the stall; no beat lost or duplicated.
4. cmd_cerrar and cmd_nuevo rising in the same cycle -> CLOSE first (cmd_done=100, editor_en=0), then CLEAR runs; editor_en=1 after cmd_done=001.
5. In CLOSED, pulse cmd_guardar -> no save_valid and no done pulse; editor_en stays 0.
6. Assert reset at beat 300 of a save -> save_valid=0 and busy=0 next cycle, state IDLE. Command levels held high through reset generate no command.
